// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined W-bit logic gate: operation encoding
// and the width of the operation select.
package logic_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

endpackage

// File: rtl/logic_gate_alu.sv
// Purely combinational W-bit bitwise operation selected by op.
// NOT and PASS act on operand a only; b is ignored for those two.
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_e          op,
    output logic [W-1:0] y
);

    always_comb begin
        // NOTE: y gets a default before the case so every path assigns it and no latch is inferred.
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline around logic_gate_alu: stage 1 captures the
// operands, stage 2 registers the result and its reductions; counts handshakes.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic             y_all,
    output logic             y_none,
    output logic [CNT_W-1:0] out_count
);

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    op_e          s1_op;
    logic         s1_adv;
    logic         s2_adv;
    logic         accept;
    logic [W-1:0] alu_y;

    // A stage may move when the one ahead of it is empty or draining this cycle.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand/result registers are reset as well as the valids, so they never hold X while idle.
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
        end else begin
            // NOTE: non-blocking assignments keep every stage reading last cycle's values.
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op_e'(op);
            end
        end
    end

    logic_gate_alu #(
        .W (W)
    ) u_alu (
        .a  (s1_a),
        .b  (s1_b),
        .op (s1_op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_all     <= 1'b0;
            y_none    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y      <= alu_y;
                y_all  <= &alu_y;
                y_none <= ~|alu_y;
            end
        end
    end

    // Reset has priority, so a handshake in the reset cycle is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: directed scenarios plus a random
// stream scored against a queue-based reference model.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       y_all;
    logic       y_none;
    logic [7:0] out_count;

    // Second instance with a 2-bit counter, sharing all inputs, to observe wrap.
    logic       in_ready_c2;
    logic       out_valid_c2;
    logic [3:0] y_c2;
    logic       y_all_c2;
    logic       y_none_c2;
    logic [1:0] out_count_c2;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy of the two slots plus in-order results in flight.
    logic       m_v0 = 1'b0;
    logic       m_v1 = 1'b0;
    int         m_cnt = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    logic_gate_pipe #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_all(y_all), .y_none(y_none), .out_count(out_count)
    );

    logic_gate_pipe #(.W(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c2),
        .a(a), .b(b), .op(op), .out_valid(out_valid_c2), .out_ready(out_ready),
        .y(y_c2), .y_all(y_all_c2), .y_none(y_none_c2), .out_count(out_count_c2)
    );

    // Each op as a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [3:0] ref_op(input logic [3:0] fa, input logic [3:0] fb,
                                          input logic [2:0] fop);
        logic [3:0] tt [8];
        logic [3:0] row;
        logic [3:0] r;
        tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        row = tt[fop];
        for (int i = 0; i < 4; i++) r[i] = row[{fa[i], fb[i]}];
        return r;
    endfunction

    task automatic drive(input logic iv, input logic [3:0] ia, input logic [3:0] ib,
                         input logic [2:0] iop, input logic ordy, input logic irst);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        rst       = irst;
        #1;
    endtask

    // Advance one rising edge and update the reference model from the inputs.
    task automatic edge_step();
        logic adv1;
        logic adv2;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_v0  = 1'b0;
            m_v1  = 1'b0;
            m_cnt = 0;
        end else begin
            adv2 = !m_v1 || out_ready;
            adv1 = !m_v0 || adv2;
            if (m_v1 && out_ready) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (adv1 && in_valid) exp_q.push_back(ref_op(a, b, op));
            if (adv2) m_v1 = m_v0;
            if (adv1) m_v0 = in_valid;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 4'h5, 4'h3, 3'd2, 1'b1, 1'b1);
        edge_step();
        drive(1'b1, 4'hA, 4'h6, 3'd1, 1'b1, 1'b1);
        edge_step();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (y !== 4'h0) begin errors++; $display("FAIL reset_y: got %h want 0", y); end
        checks++; if (y_all !== 1'b0 || y_none !== 1'b0) begin errors++; $display("FAIL reset_reductions: got all=%b none=%b want 0 0", y_all, y_none); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++; if (out_count_c2 !== 2'd0) begin errors++; $display("FAIL reset_count_c2: got %0d want 0", out_count_c2); end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_output: cycle %0d got %b want 0", i, out_valid); end
        end
        edge_step();
    endtask

    task automatic test_truth_sweep();
        logic [3:0] tbl [8];
        tbl = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 4'b1100, 4'b1010, 3'(i), 1'b1, 1'b0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready: step %0d got %b want 1", i, in_ready); end
            if (i >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid: op %0d got %b want 1", i - 2, out_valid); end
                checks++; if (y !== tbl[i-2]) begin errors++; $display("FAIL sweep_y: op %0d got %b want %b", i - 2, y, tbl[i-2]); end
                checks++; if (y_all !== 1'b0 || y_none !== 1'b0) begin errors++; $display("FAIL sweep_reductions: op %0d got all=%b none=%b want 0 0", i - 2, y_all, y_none); end
            end
            edge_step();
        end
    endtask

    task automatic test_reductions();
        drive(1'b1, 4'hF, 4'hF, 3'd0, 1'b1, 1'b0);
        edge_step();
        drive(1'b1, 4'hF, 4'h0, 3'd6, 1'b1, 1'b0);
        edge_step();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || y !== 4'hF || y_all !== 1'b1 || y_none !== 1'b0) begin
            errors++; $display("FAIL red_and_all: got v=%b y=%h all=%b none=%b want 1 F 1 0", out_valid, y, y_all, y_none);
        end
        edge_step();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || y !== 4'h0 || y_all !== 1'b0 || y_none !== 1'b1) begin
            errors++; $display("FAIL red_not_none: got v=%b y=%h all=%b none=%b want 1 0 0 1", out_valid, y, y_all, y_none);
        end
        edge_step();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL red_drained: got %b want 0", out_valid); end
        edge_step();
    endtask

    task automatic test_backpressure();
        logic [3:0] ia [4];
        logic [3:0] ib [4];
        logic [2:0] iop [4];
        logic [3:0] want [4];
        logic       exp_rdy;
        int sent = 0;
        int got = 0;
        int dut_acc = 0;
        int idx;
        for (int k = 0; k < 4; k++) begin
            ia[k]   = 4'($urandom);
            ib[k]   = 4'($urandom);
            iop[k]  = 3'($urandom);
            want[k] = ref_op(ia[k], ib[k], iop[k]);
        end
        for (int c = 0; c < 6; c++) begin
            idx = (sent < 4) ? sent : 0;
            drive(sent < 4, ia[idx], ib[idx], iop[idx], 1'b0, 1'b0);
            exp_rdy = !m_v0 || !m_v1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b want %b", c, in_ready, exp_rdy); end
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || y !== want[0]) begin
                    errors++; $display("FAIL bp_hold: cycle %0d got v=%b y=%h want 1 %h", c, out_valid, y, want[0]);
                end
            end
            if (in_valid && in_ready) dut_acc++;
            if (in_valid && exp_rdy) sent++;
            edge_step();
        end
        checks++; if (dut_acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", dut_acc); end
        for (int c = 0; c < 20 && got < 4; c++) begin
            idx = (sent < 4) ? sent : 0;
            drive(sent < 4, ia[idx], ib[idx], iop[idx], 1'b1, 1'b0);
            if (out_valid === 1'b1) begin
                checks++; if (y !== want[got]) begin errors++; $display("FAIL bp_order: result %0d got %h want %h", got, y, want[got]); end
                got++;
            end
            if (in_valid && (!m_v0 || !m_v1 || out_ready)) sent++;
            edge_step();
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d results want 4", got); end
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
        edge_step();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] tbl [5];
        logic hs;
        int sent = 0;
        int got = 0;
        tbl = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b1);
        edge_step();
        for (int c = 0; c < 12 && got < 5; c++) begin
            drive(sent < 5, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, 1'b0);
            hs = out_valid && out_ready;
            if (in_valid && (!m_v0 || !m_v1 || out_ready)) sent++;
            edge_step();
            #1;
            if (hs) begin
                checks++; if (out_count_c2 !== tbl[got]) begin errors++; $display("FAIL wrap_c2: handshake %0d got %0d want %0d", got, out_count_c2, tbl[got]); end
                checks++; if (out_count !== 8'(got + 1)) begin errors++; $display("FAIL wrap_c8: handshake %0d got %0d want %0d", got, out_count, got + 1); end
                got++;
            end
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL wrap_handshakes: got %0d want 5", got); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 4'h3, 4'h5, 3'd1, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 4'h9, 4'h6, 3'd2, 1'b0, 1'b0);
        edge_step();
        drive(1'b1, 4'h7, 4'h7, 3'd0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got rdy=%b v=%b want 0 1", in_ready, out_valid); end
        drive(1'b1, 4'h7, 4'h7, 3'd0, 1'b1, 1'b1);
        edge_step();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_count !== 8'd0 || out_count_c2 !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d/%0d want 0/0", out_count, out_count_c2); end
        checks++; if (in_ready !== 1'b1 || y !== 4'h0) begin errors++; $display("FAIL mid_state: got rdy=%b y=%h want 1 0", in_ready, y); end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d got %b want 0", i, out_valid); end
        end
        edge_step();
    endtask

    task automatic test_random();
        logic       exp_rdy;
        logic [3:0] exp_y;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
            exp_rdy = !m_v0 || !m_v1 || out_ready;
            checks++; if (out_valid !== m_v1) begin errors++; $display("FAIL rnd_valid: cycle %0d got %b want %b", c, out_valid, m_v1); end
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, in_ready, exp_rdy); end
            checks++; if (out_count !== 8'(m_cnt) || out_count_c2 !== 2'(m_cnt)) begin
                errors++; $display("FAIL rnd_count: cycle %0d got %0d/%0d want %0d/%0d", c, out_count, out_count_c2, 8'(m_cnt), 2'(m_cnt));
            end
            if (m_v1 && exp_q.size() > 0) begin
                exp_y = exp_q[0];
                checks++; if (y !== exp_y || y_all !== (&exp_y) || y_none !== (~|exp_y)) begin
                    errors++; $display("FAIL rnd_result: cycle %0d got y=%h all=%b none=%b want %h %b %b", c, y, y_all, y_none, exp_y, &exp_y, ~|exp_y);
                end
            end
            edge_step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        op        = 3'd0;
        out_ready = 1'b1;
        test_reset();
        test_truth_sweep();
        test_reductions();
        test_backpressure();
        test_counter_wrap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
